// File: rtl/escalonador_rr.sv
// escalonador_rr: round-robin preemptive scheduler for the program counter.
// Slots are fixed-size regions of program memory; slot 0 holds the OS and is
// never selected. Each user slot keeps a ready bit and a saved PC offset, and
// the running slot is preempted when its retired-instruction count reaches
// the programmable quantum, when it yields, or when it ends.
module escalonador_rr #(
   parameter int NUM_PROG        = 8,
   parameter int SLOT_SIZE       = 200,
   parameter int ADDR_W          = 32,
   parameter int QUANTUM_DEFAULT = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        stop,
   input  logic                        inst_exec,
   input  logic [ADDR_W-1:0]           pc_cur,
   input  logic                        quantum_wr,
   input  logic [31:0]                 quantum_in,
   input  logic                        prog_add,
   input  logic [$clog2(NUM_PROG)-1:0] prog_id,
   input  logic                        prog_end,
   input  logic                        yield,
   output logic                        switch_go,
   output logic [ADDR_W-1:0]           next_pc,
   output logic [$clog2(NUM_PROG)-1:0] cur_prog,
   output logic                        running,
   output logic                        timeout,
   output logic                        busy
);

   localparam int ID_W = $clog2(NUM_PROG);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PICK = 2'd1,
      LOAD = 2'd2,
      RUN  = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [NUM_PROG-1:0] ready;
   logic [ADDR_W-1:0] offset [NUM_PROG];
   logic [31:0]       quantum;
   logic [31:0]       qcount;

   logic              tmo;
   logic              ev_end;
   logic              ev_yield;
   logic              ev_any;
   logic              add_ok;
   logic              found;
   logic [ID_W-1:0]   winner;

   // k-th candidate of the rotating search (k = 1..NUM_PROG-1): starts just
   // after cur and wraps NUM_PROG-1 -> 1, so slot 0 never appears and cur
   // itself comes last.
   function automatic logic [ID_W-1:0] slot_at(input logic [ID_W-1:0] cur, input int k);
      int base;
      base = (cur == '0) ? (NUM_PROG - 2) : (int'(cur) - 1);
      return ID_W'(((base + k) % (NUM_PROG - 1)) + 1);
   endfunction

   // Switch events are only sampled in RUN while not frozen; quantum 0 disables preemption
   always_comb begin
      tmo      = (state == RUN) && !stop && inst_exec &&
                 (quantum != 32'd0) && (qcount == quantum - 32'd1);
      ev_end   = (state == RUN) && !stop && prog_end;
      ev_yield = (state == RUN) && !stop && yield;
      ev_any   = ev_end || ev_yield || tmo;
      // A running slot keeps its context; slot 0 is never made ready
      add_ok   = prog_add && (prog_id != '0) &&
                 !((state == RUN) && (prog_id == cur_prog));
   end

   // Rotating search for the next ready slot
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k < NUM_PROG; k++) begin
         if (!found && ready[slot_at(cur_prog, k)]) begin
            found  = 1'b1;
            winner = slot_at(cur_prog, k);
         end
      end
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; stop freezes every transition
   always_comb begin
      state_nxt = state;
      if (!stop) begin
         case (state)
            IDLE: if ((|ready) || add_ok) state_nxt = PICK;
            PICK: state_nxt = found ? LOAD : IDLE;
            LOAD: state_nxt = RUN;
            RUN:  if (ev_any) state_nxt = PICK;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Outputs decoded from the state; switch_go drops as soon as reset clears the state
   always_comb begin
      switch_go = (state == LOAD);
      running   = (state == RUN);
      busy      = (state == PICK) || (state == LOAD);
      timeout   = tmo;
   end

   // Selected slot and its absolute load address, latched when PICK finds a winner
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur_prog <= '0;
         next_pc  <= '0;
      end else if ((state == PICK) && !stop && found) begin
         cur_prog <= winner;
         next_pc  <= ADDR_W'(winner) * ADDR_W'(SLOT_SIZE) + offset[winner];
      end
   end

   // Quantum register and retired-instruction counter (restarted on every load)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         quantum <= 32'(QUANTUM_DEFAULT);
         qcount  <= '0;
      end else begin
         if (quantum_wr) quantum <= quantum_in;
         if (!stop) begin
            if (state == LOAD)                 qcount <= '0;
            else if ((state == RUN) && inst_exec) qcount <= qcount + 32'd1;
         end
      end
   end

   // Per-slot ready bits and saved offsets; an end on the running slot overrides an add
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ready <= '0;
         for (int i = 0; i < NUM_PROG; i++) offset[i] <= '0;
      end else begin
         if (add_ok) begin
            ready[prog_id]  <= 1'b1;
            offset[prog_id] <= '0;
         end
         if (ev_end) begin
            ready[cur_prog] <= 1'b0;
         end else if (ev_yield || tmo) begin
            offset[cur_prog] <= pc_cur + ADDR_W'(1) - ADDR_W'(cur_prog) * ADDR_W'(SLOT_SIZE);
         end
      end
   end

endmodule

// File: tb/tb_escalonador_rr.sv
// Directed bench for escalonador_rr: a table of per-cycle vectors for basic
// scheduling and round-robin preemption, then hand-written sequences for
// simultaneous events, quantum 0, stop, and asynchronous reset.
module tb_escalonador_rr;

   logic        clock = 1'b0;
   logic        reset;
   logic        stop;
   logic        inst_exec;
   logic [31:0] pc_cur;
   logic        quantum_wr;
   logic [31:0] quantum_in;
   logic        prog_add;
   logic [2:0]  prog_id;
   logic        prog_end;
   logic        yield;
   logic        switch_go;
   logic [31:0] next_pc;
   logic [2:0]  cur_prog;
   logic        running;
   logic        timeout;
   logic        busy;

   int total  = 0;
   int passed = 0;

   // {switch_go, running, busy, timeout}
   localparam logic [3:0] F_IDLE = 4'b0000;
   localparam logic [3:0] F_PICK = 4'b0010;
   localparam logic [3:0] F_LOAD = 4'b1010;
   localparam logic [3:0] F_RUN  = 4'b0100;
   localparam logic [3:0] F_TMO  = 4'b0101;

   escalonador_rr #(
      .NUM_PROG(8), .SLOT_SIZE(200), .ADDR_W(32), .QUANTUM_DEFAULT(16)
   ) dut (
      .clock(clock), .reset(reset), .stop(stop), .inst_exec(inst_exec),
      .pc_cur(pc_cur), .quantum_wr(quantum_wr), .quantum_in(quantum_in),
      .prog_add(prog_add), .prog_id(prog_id), .prog_end(prog_end), .yield(yield),
      .switch_go(switch_go), .next_pc(next_pc), .cur_prog(cur_prog),
      .running(running), .timeout(timeout), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        ie;
      logic [31:0] pc;
      logic        add;
      logic [2:0]  id;
      logic        pend;
      logic        yld;
      logic        qwr;
      logic [31:0] qin;
      logic [3:0]  ef;
      logic [2:0]  ecur;
      logic [31:0] enpc;
   } vec_t;

   vec_t tbl [22];

   function automatic vec_t v(input logic ie, input logic [31:0] pc, input logic add,
                              input logic [2:0] id, input logic pend, input logic yld,
                              input logic qwr, input logic [31:0] qin, input logic [3:0] ef,
                              input logic [2:0] ecur, input logic [31:0] enpc);
      vec_t r;
      r.ie = ie; r.pc = pc; r.add = add; r.id = id; r.pend = pend; r.yld = yld;
      r.qwr = qwr; r.qin = qin; r.ef = ef; r.ecur = ecur; r.enpc = enpc;
      return r;
   endfunction

   task automatic clr();
      stop = 0; inst_exec = 0; pc_cur = 0; quantum_wr = 0; quantum_in = 0;
      prog_add = 0; prog_id = 0; prog_end = 0; yield = 0;
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic check(input string name, input logic [3:0] ef, input logic [2:0] ec,
                        input logic [31:0] en);
      logic [3:0] af;
      af = {switch_go, running, busy, timeout};
      total++;
      if (af === ef && cur_prog === ec && next_pc === en) passed++;
      else $display("FAIL %s: got sg/run/busy/tmo=%b cur_prog=%0d next_pc=%0d, want %b cur_prog=%0d next_pc=%0d",
                    name, af, cur_prog, next_pc, ef, ec, en);
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   task automatic do_reset();
      reset = 1;
      clr();
      #2;
      check("reset_values", F_IDLE, 3'd0, 32'd0);
      @(negedge clock);
      reset = 0;
   endtask

   int n_tmo;
   int n_idle;

   initial begin
      // Slot 2 alone, end it, then slots 1/2 with quantum 3 preempting each other
      tbl[0]  = v(0, 0,   0, 0, 0, 0, 0, 0, F_IDLE, 0, 0);
      tbl[1]  = v(0, 0,   1, 2, 0, 0, 0, 0, F_IDLE, 0, 0);
      tbl[2]  = v(0, 0,   0, 0, 0, 0, 0, 0, F_PICK, 0, 0);
      tbl[3]  = v(0, 0,   0, 0, 0, 0, 0, 0, F_LOAD, 2, 400);
      tbl[4]  = v(0, 0,   0, 0, 0, 0, 0, 0, F_RUN,  2, 400);
      tbl[5]  = v(0, 0,   0, 0, 1, 0, 0, 0, F_RUN,  2, 400);
      tbl[6]  = v(0, 0,   0, 0, 0, 0, 0, 0, F_PICK, 2, 400);
      tbl[7]  = v(0, 0,   0, 0, 0, 0, 0, 0, F_IDLE, 2, 400);
      tbl[8]  = v(0, 0,   1, 1, 0, 0, 1, 3, F_IDLE, 2, 400);
      tbl[9]  = v(0, 0,   1, 2, 0, 0, 0, 0, F_PICK, 2, 400);
      tbl[10] = v(0, 0,   0, 0, 0, 0, 0, 0, F_LOAD, 1, 200);
      tbl[11] = v(1, 203, 0, 0, 0, 0, 0, 0, F_RUN,  1, 200);
      tbl[12] = v(1, 204, 0, 0, 0, 0, 0, 0, F_RUN,  1, 200);
      tbl[13] = v(1, 205, 0, 0, 0, 0, 0, 0, F_TMO,  1, 200);
      tbl[14] = v(0, 0,   0, 0, 0, 0, 0, 0, F_PICK, 1, 200);
      tbl[15] = v(0, 0,   0, 0, 0, 0, 0, 0, F_LOAD, 2, 400);
      tbl[16] = v(1, 400, 0, 0, 0, 0, 0, 0, F_RUN,  2, 400);
      tbl[17] = v(1, 401, 0, 0, 0, 0, 0, 0, F_RUN,  2, 400);
      tbl[18] = v(1, 402, 0, 0, 0, 0, 0, 0, F_TMO,  2, 400);
      tbl[19] = v(0, 0,   0, 0, 0, 0, 0, 0, F_PICK, 2, 400);
      tbl[20] = v(0, 0,   0, 0, 0, 0, 0, 0, F_LOAD, 1, 206);
      tbl[21] = v(0, 0,   0, 0, 0, 0, 0, 0, F_RUN,  1, 206);

      reset = 1;
      clr();
      @(negedge clock);
      @(negedge clock);
      check("reset_initial", F_IDLE, 3'd0, 32'd0);
      reset = 0;

      for (int i = 0; i < 22; i++) begin
         inst_exec  = tbl[i].ie;
         pc_cur     = tbl[i].pc;
         prog_add   = tbl[i].add;
         prog_id    = tbl[i].id;
         prog_end   = tbl[i].pend;
         yield      = tbl[i].yld;
         quantum_wr = tbl[i].qwr;
         quantum_in = tbl[i].qin;
         #1;
         check($sformatf("vec%0d", i), tbl[i].ef, tbl[i].ecur, tbl[i].enpc);
         tick();
      end

      // Simultaneous yield and timeout, reselection of the only ready slot, quantum 0
      do_reset();
      prog_add = 1; prog_id = 2; quantum_wr = 1; quantum_in = 1;
      #1 check("c_idle", F_IDLE, 0, 0);
      tick();
      clr();
      #1 check("c_pick", F_PICK, 0, 0);
      tick();
      #1 check("c_load", F_LOAD, 2, 400);
      tick();
      inst_exec = 1; yield = 1; pc_cur = 410;
      #1 check("c_yield_tmo", F_TMO, 2, 400);
      tick();
      clr();
      #1 check("c_pick_once", F_PICK, 2, 400);
      tick();
      #1 check("c_reload_offset", F_LOAD, 2, 411);
      tick();
      quantum_wr = 1; quantum_in = 0;
      #1 check("c_run", F_RUN, 2, 411);
      tick();
      clr();
      n_tmo = 0; n_idle = 0;
      for (int i = 0; i < 100; i++) begin
         inst_exec = 1; pc_cur = 411 + i;
         #1;
         if (timeout) n_tmo++;
         if (!running) n_idle++;
         tick();
      end
      chk_int("q0_no_timeout", n_tmo, 0);
      chk_int("q0_still_running", n_idle, 0);

      // End of the only ready program, then a late add of slot 5
      clr(); prog_end = 1;
      #1 check("c_end", F_RUN, 2, 411);
      tick();
      clr();
      #1 check("c_pick_none", F_PICK, 2, 411);
      tick();
      #1 check("c_idle_after_end", F_IDLE, 2, 411);
      tick();
      prog_add = 1; prog_id = 5;
      tick();
      clr();
      #1 check("c_pick5", F_PICK, 2, 411);
      tick();
      #1 check("c_load5", F_LOAD, 5, 1000);
      tick();

      // stop holds qcount and ignores events; counting resumes from the held value
      quantum_wr = 1; quantum_in = 4;
      #1 check("d_run", F_RUN, 5, 1000);
      tick();
      clr();
      inst_exec = 1; pc_cur = 1000;
      tick();
      pc_cur = 1001;
      tick();
      n_tmo = 0; n_idle = 0;
      for (int i = 0; i < 5; i++) begin
         stop = 1; inst_exec = 1; pc_cur = 1002; yield = (i == 2);
         #1;
         if (timeout) n_tmo++;
         if (!running) n_idle++;
         tick();
      end
      chk_int("stop_no_timeout", n_tmo, 0);
      chk_int("stop_holds_run", n_idle, 0);
      clr(); inst_exec = 1; pc_cur = 1002;
      #1 check("d_resume", F_RUN, 5, 1000);
      tick();
      pc_cur = 1007;
      #1 check("d_timeout", F_TMO, 5, 1000);
      tick();
      clr();
      #1 check("d_pick", F_PICK, 5, 1000);
      tick();
      #1 check("d_reload", F_LOAD, 5, 1008);
      tick();

      // Asynchronous reset in LOAD, then an add of slot 0 must not wake the scheduler
      do_reset();
      prog_add = 1; prog_id = 3;
      tick();
      clr();
      tick();
      #1 check("e_load", F_LOAD, 3, 600);
      #2 reset = 1;
      #1 check("e_async_reset", F_IDLE, 0, 0);
      @(negedge clock);
      reset = 0;
      prog_add = 1; prog_id = 0;
      #1 check("e_add_slot0", F_IDLE, 0, 0);
      tick();
      clr();
      for (int i = 0; i < 3; i++) begin
         #1 check($sformatf("e_stay_idle%0d", i), F_IDLE, 0, 0);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
